// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU issue arbiter: ALU control bit indices, lane encoding,
// multiply-latency bound and the op-class decode used to size the completion delay.
package alu_arb_pkg;

    localparam int SIG_W = 12;

    localparam int ADD = 0;
    localparam int SUB = 1;
    localparam int AND = 2;
    localparam int OR  = 3;
    localparam int MUL = 4;
    localparam int XOR = 5;
    localparam int NOT = 6;
    localparam int MOV = 7;
    localparam int CMP = 8;
    localparam int LSL = 9;
    localparam int ASR = 10;
    localparam int LSR = 11;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int MAX_MUL_LAT = 8;

    // Mirrors the ALU priority decode: lower-indexed ops shadow the multiply bit.
    function automatic logic is_mul(input logic [SIG_W-1:0] sig);
        return sig[MUL] & ~|sig[MUL-1:ADD];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter with a round-robin pointer. Defining ALU_ARB_FIXED_PRIO_EN
// replaces it with fixed lane0 priority and removes the pointer.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    assign gnt0_o = en_i & req0_i;
    assign gnt1_o = en_i & req1_i & ~req0_i;
`else
    logic ptr_q, ptr_d;
    logic pick1;

    // Lane1 wins when it is the only requester or the pointer favours it.
    assign pick1  = req1_i & (~req0_i | (ptr_q == LANE1));
    assign gnt1_o = en_i & pick1;
    assign gnt0_o = en_i & req0_i & ~pick1;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt0_o) begin
            ptr_d = LANE1;
        end else if (gnt1_o) begin
            ptr_d = LANE0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= LANE0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares the execute-stage ALU between two issue lanes, blocks grants during multiplies
// and returns per-lane completion pulses. Optional fixed priority: ALU_ARB_FIXED_PRIO_EN.
module alu_issue_arbiter
    import alu_arb_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [SIG_W-1:0] alusig0_i,
    input  logic [SIG_W-1:0] alusig1_i,
    input  logic [15:0]      op1_0_i,
    input  logic [15:0]      op2_0_i,
    input  logic [15:0]      op1_1_i,
    input  logic [15:0]      op2_1_i,
    input  logic [4:0]       immx0_i,
    input  logic [4:0]       immx1_i,
    input  logic             isimm0_i,
    input  logic             isimm1_i,
    input  logic [15:0]      instr0_i,
    input  logic [15:0]      instr1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             alu_valid_o,
    output logic [SIG_W-1:0] alu_sig_o,
    output logic [15:0]      alu_op1_o,
    output logic [15:0]      alu_op2_o,
    output logic [4:0]       alu_immx_o,
    output logic             alu_isimm_o,
    output logic [15:0]      alu_instr_o,
    output logic             alu_lane_o,
    output logic             busy_o,
    output logic             done0_o,
    output logic             done1_o
);

    localparam int OCC_W = $clog2(MAX_MUL_LAT);

    logic             alu_valid_q;
    logic [SIG_W-1:0] alu_sig_q;
    logic [15:0]      alu_op1_q, alu_op2_q, alu_instr_q;
    logic [4:0]       alu_immx_q;
    logic             alu_isimm_q, alu_lane_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [MUL_LAT-1:0] pv_q, pv_d, pl_q, pl_d, ins_mask;
    logic             done0_q, done0_d, done1_q, done1_d;

    logic             xfer, sel_lane, sel_mul, busy;
    logic [SIG_W-1:0] sel_sig;
    logic [15:0]      sel_op1, sel_op2, sel_instr;
    logic [4:0]       sel_immx;
    logic             sel_isimm;

    assign busy = (occ_q != '0);

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (~busy & ~flush_i),
        .req0_i (req0_i),
        .req1_i (req1_i),
        .gnt0_o (gnt0_o),
        .gnt1_o (gnt1_o)
    );

    // A grant already implies a request, so any grant is a transfer.
    assign xfer     = gnt0_o | gnt1_o;
    assign sel_lane = gnt1_o ? LANE1 : LANE0;

    always_comb begin
        sel_sig   = alusig0_i;
        sel_op1   = op1_0_i;
        sel_op2   = op2_0_i;
        sel_immx  = immx0_i;
        sel_isimm = isimm0_i;
        sel_instr = instr0_i;
        if (sel_lane == LANE1) begin
            sel_sig   = alusig1_i;
            sel_op1   = op1_1_i;
            sel_op2   = op2_1_i;
            sel_immx  = immx1_i;
            sel_isimm = isimm1_i;
            sel_instr = instr1_i;
        end
    end

    assign sel_mul = is_mul(sel_sig);

    // Latency-1 tags enter at stage 0, multiplies at the top so they emerge after MUL_LAT edges.
    assign ins_mask = sel_mul ? (MUL_LAT'(1) << (MUL_LAT - 1)) : MUL_LAT'(1);

    always_comb begin
        occ_d = occ_q;
        pv_d  = (pv_q >> 1) | (xfer ? ins_mask : '0);
        pl_d  = (pl_q >> 1) | ((xfer && sel_lane == LANE1) ? ins_mask : '0);
        if (flush_i) begin
            occ_d = '0;
            pv_d  = '0;
        end else if (xfer && sel_mul) begin
            occ_d = OCC_W'(MUL_LAT - 1);
        end else if (busy) begin
            occ_d = occ_q - OCC_W'(1);
        end
        done0_d = ~flush_i & pv_q[0] & (pl_q[0] == LANE0);
        done1_d = ~flush_i & pv_q[0] & (pl_q[0] == LANE1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_valid_q <= 1'b0;
            alu_sig_q   <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_immx_q  <= '0;
            alu_isimm_q <= 1'b0;
            alu_instr_q <= '0;
            alu_lane_q  <= LANE0;
            occ_q       <= '0;
            pv_q        <= '0;
            pl_q        <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
        end else begin
            alu_valid_q <= xfer;
            if (xfer) begin
                alu_sig_q   <= sel_sig;
                alu_op1_q   <= sel_op1;
                alu_op2_q   <= sel_op2;
                alu_immx_q  <= sel_immx;
                alu_isimm_q <= sel_isimm;
                alu_instr_q <= sel_instr;
                alu_lane_q  <= sel_lane;
            end
            occ_q   <= occ_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign alu_valid_o = alu_valid_q;
    assign alu_sig_o   = alu_sig_q;
    assign alu_op1_o   = alu_op1_q;
    assign alu_op2_o   = alu_op2_q;
    assign alu_immx_o  = alu_immx_q;
    assign alu_isimm_o = alu_isimm_q;
    assign alu_instr_o = alu_instr_q;
    assign alu_lane_o  = alu_lane_q;
    assign busy_o      = busy;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: MUL_LAT=3 instance plus a MUL_LAT=1 instance
// sharing the same stimulus. Expectations follow ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [11:0] alusig0 = '0, alusig1 = '0;
    logic [15:0] op1_0 = '0, op2_0 = '0, op1_1 = '0, op2_1 = '0;
    logic [4:0]  immx0 = '0, immx1 = '0;
    logic        isimm0 = 1'b0, isimm1 = 1'b0;
    logic [15:0] instr0 = '0, instr1 = '0;

    logic        gnt0_a, gnt1_a, alu_valid_a, alu_isimm_a, alu_lane_a, busy_a, done0_a, done1_a;
    logic [11:0] alu_sig_a;
    logic [15:0] alu_op1_a, alu_op2_a, alu_instr_a;
    logic [4:0]  alu_immx_a;
    logic        gnt0_b, gnt1_b, alu_valid_b, alu_isimm_b, alu_lane_b, busy_b, done0_b, done1_b;
    logic [11:0] alu_sig_b;
    logic [15:0] alu_op1_b, alu_op2_b, alu_instr_b;
    logic [4:0]  alu_immx_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.MUL_LAT(3)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req0_i(req0), .req1_i(req1),
        .alusig0_i(alusig0), .alusig1_i(alusig1),
        .op1_0_i(op1_0), .op2_0_i(op2_0), .op1_1_i(op1_1), .op2_1_i(op2_1),
        .immx0_i(immx0), .immx1_i(immx1), .isimm0_i(isimm0), .isimm1_i(isimm1),
        .instr0_i(instr0), .instr1_i(instr1),
        .gnt0_o(gnt0_a), .gnt1_o(gnt1_a), .alu_valid_o(alu_valid_a), .alu_sig_o(alu_sig_a),
        .alu_op1_o(alu_op1_a), .alu_op2_o(alu_op2_a), .alu_immx_o(alu_immx_a),
        .alu_isimm_o(alu_isimm_a), .alu_instr_o(alu_instr_a), .alu_lane_o(alu_lane_a),
        .busy_o(busy_a), .done0_o(done0_a), .done1_o(done1_a)
    );

    alu_issue_arbiter #(.MUL_LAT(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req0_i(req0), .req1_i(req1),
        .alusig0_i(alusig0), .alusig1_i(alusig1),
        .op1_0_i(op1_0), .op2_0_i(op2_0), .op1_1_i(op1_1), .op2_1_i(op2_1),
        .immx0_i(immx0), .immx1_i(immx1), .isimm0_i(isimm0), .isimm1_i(isimm1),
        .instr0_i(instr0), .instr1_i(instr1),
        .gnt0_o(gnt0_b), .gnt1_o(gnt1_b), .alu_valid_o(alu_valid_b), .alu_sig_o(alu_sig_b),
        .alu_op1_o(alu_op1_b), .alu_op2_o(alu_op2_b), .alu_immx_o(alu_immx_b),
        .alu_isimm_o(alu_isimm_b), .alu_instr_o(alu_instr_b), .alu_lane_o(alu_lane_b),
        .busy_o(busy_b), .done0_o(done0_b), .done1_o(done1_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req0 = 1'b0;
        req1 = 1'b0;
        flush = 1'b0;
    endtask

    logic [3:0] exp_lane;
    int         done_seen;

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_lane = 4'b0000;
`else
        exp_lane = 4'b1010;  // bit k = lane of grant k: 0,1,0,1
`endif
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(alu_valid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'({done0_a, done1_a}), 0);
        check("rst_fields", 32'({alu_sig_a, alu_op1_a, alu_lane_a}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single latency-1 add from lane0.
        @(negedge clk);
        req0 = 1'b1; alusig0 = 12'h001; op1_0 = 16'd5; op2_0 = 16'd7; instr0 = 16'h1234;
        #1 check("t1_gnt", 32'({gnt0_a, gnt1_a}), 32'b10);
        @(negedge clk);
        $display("[TB] add lane0 issued");
        check("t1_valid", 32'(alu_valid_a), 1);
        check("t1_op1", 32'(alu_op1_a), 5);
        check("t1_op2", 32'(alu_op2_a), 7);
        check("t1_lane", 32'(alu_lane_a), 0);
        check("t1_done_early", 32'({done0_a, done1_a}), 0);
        req0 = 1'b0;
        @(negedge clk);
        check("t1_done", 32'({done0_a, done1_a}), 32'b10);
        check("t1_valid_clr", 32'(alu_valid_a), 0);
        @(negedge clk);
        check("t1_done_once", 32'({done0_a, done1_a}), 0);

        // Lane1 multiply, then lane0 add waits out the busy window.
        req1 = 1'b1; alusig1 = 12'h010; op1_1 = 16'd3;
        #1 check("t3_gnt_mul", 32'({gnt0_a, gnt1_a}), 32'b01);
        @(negedge clk);
        $display("[TB] mul lane1 issued");
        check("t3_busy0", 32'(busy_a), 1);
        check("t3_sig", 32'(alu_sig_a), 32'h010);
        check("t3_lane", 32'(alu_lane_a), 1);
        req1 = 1'b0; req0 = 1'b1; alusig0 = 12'h001; op1_0 = 16'd9;
        #1 check("t3_gnt_blk0", 32'(gnt0_a), 0);
        @(negedge clk);
        check("t3_busy1", 32'(busy_a), 1);
        check("t3_gnt_blk1", 32'(gnt0_a), 0);
        check("t3_valid_gap", 32'(alu_valid_a), 0);
        @(negedge clk);
        check("t3_busy2", 32'(busy_a), 0);
        check("t3_gnt_ok", 32'(gnt0_a), 1);
        check("t3_nodone", 32'({done0_a, done1_a}), 0);
        @(negedge clk);
        $display("[TB] add lane0 issued after mul");
        check("t3_done1", 32'({done0_a, done1_a}), 32'b01);
        check("t3_op1", 32'(alu_op1_a), 9);
        check("t3_lane0", 32'(alu_lane_a), 0);
        req0 = 1'b0;
        @(negedge clk);
        check("t3_done0", 32'({done0_a, done1_a}), 32'b10);
        @(negedge clk);

        // Flush: blocks grants, kills an in-flight multiply.
        req0 = 1'b1; flush = 1'b1;
        #1 check("fl_gnt_idle", 32'(gnt0_a), 0);
        flush = 1'b0; alusig0 = 12'h010;
        #1 check("fl_gnt_mul", 32'(gnt0_a), 1);
        @(negedge clk);
        $display("[TB] mul lane0 issued before flush");
        check("fl_busy_pre", 32'(busy_a), 1);
        alusig0 = 12'h001; flush = 1'b1;
        #1 check("fl_gnt", 32'(gnt0_a), 0);
        @(negedge clk);
        check("fl_busy", 32'(busy_a), 0);
        check("fl_valid", 32'(alu_valid_a), 0);
        check("fl_done", 32'({done0_a, done1_a}), 0);
        idle();
        done_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done0_a || done1_a) done_seen++;
        end
        check("fl_no_done", 32'(done_seen), 0);

        // Asynchronous reset mid-cycle during a multiply.
        req0 = 1'b1; alusig0 = 12'h010;
        @(negedge clk);
        check("rs_busy_pre", 32'(busy_a), 1);
        req0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rs_busy", 32'(busy_a), 0);
        check("rs_valid", 32'(alu_valid_a), 0);
        check("rs_fields", 32'({alu_sig_a, alu_op1_a, alu_lane_a}), 0);
        check("rs_done", 32'({done0_a, done1_a}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done0_a || done1_a) done_seen++;
        end
        check("rs_no_done", 32'(done_seen), 0);

        // Both lanes request adds: pointer starts at lane0 after reset.
        req0 = 1'b1; req1 = 1'b1; alusig0 = 12'h001; alusig1 = 12'h002;
        op1_0 = 16'd10; op1_1 = 16'd11;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("rr_gnt%0d", k), 32'({gnt0_a, gnt1_a}),
                     exp_lane[k] ? 32'b01 : 32'b10);
            @(negedge clk);
            $display("[TB] both-request grant %0d to lane%0d", k, alu_lane_a);
            check($sformatf("rr_lane%0d", k), 32'(alu_lane_a), 32'(exp_lane[k]));
        end

        // MUL_LAT=1 instance: lane0 multiply vs lane1 add, one transfer per cycle.
        alusig0 = 12'h010; alusig1 = 12'h001;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                #1 check($sformatf("m1_busy%0d", k), 32'(busy_b), 0);
                check($sformatf("m1_gnt%0d", k), 32'({gnt0_b, gnt1_b}),
                      exp_lane[k] ? 32'b01 : 32'b10);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 4) begin
                check($sformatf("m1_valid%0d", k), 32'(alu_valid_b), 1);
            end
            if (k > 0) begin
                $display("[TB] mul_lat1 completion for grant %0d", k - 1);
                check($sformatf("m1_done%0d", k - 1), 32'({done0_b, done1_b}),
                      exp_lane[k-1] ? 32'b01 : 32'b10);
            end
        end
        @(negedge clk);
        check("m1_done_end", 32'({done0_b, done1_b}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
